issue_scoreboard: RTL and testbench

- In-order issue gate between decode (control word) and the four execute units: alu, mul, div, mem.
- Holds one decoded op per cycle at its input and decides whether it may issue this cycle, checking three things:
  - RAW/WAW hazards against a 32-entry register busy table.
  - Structural availability of the iterative divider and the memory unit.
  - Conflicts on the shared fixed-latency writeback port (alu/mul).
- Sequences the busy table, divider occupancy, memory outstanding count and writeback-slot reservations.

---
 rtl/issue_scoreboard.sv | 117 +++++++++++
 tb/tb_issue_scoreboard.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// In-order issue gate: checks register hazards, divider/memory availability and
// fixed-latency writeback-port collisions before letting a decoded op fire.
module issue_scoreboard #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MEM_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [1:0]  dec_exu_type,
  input  logic        dec_has_rd,
  input  logic        dec_has_rs1,
  input  logic        dec_has_rs2,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  output logic        issue_alu,
  output logic        issue_mul,
  output logic        issue_div,
  output logic        issue_mem,
  input  logic        div_done,
  input  logic        mem_done,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] busy_vec,
  output logic [2:0]  mem_cnt
);

  localparam logic [1:0] ExuAlu = 2'd0;
  localparam logic [1:0] ExuMul = 2'd1;
  localparam logic [1:0] ExuDiv = 2'd2;
  localparam logic [1:0] ExuMem = 2'd3;

  // Reservation lands at LAT-1 after the shift; bit 0 falls off the vector.
  localparam logic [MUL_LAT:0] AluBit = (MUL_LAT + 1)'(1) << (ALU_LAT - 1);
  localparam logic [MUL_LAT:0] MulBit = (MUL_LAT + 1)'(1) << (MUL_LAT - 1);

  logic [31:0]      busy_q, busy_d;
  logic             div_busy_q, div_busy_d;
  logic [2:0]       mem_cnt_q, mem_cnt_d;
  logic [MUL_LAT:1] slot_q, slot_d;

  logic hazard;
  logic unit_ok;
  logic fire;

  always_comb begin
    hazard = (dec_has_rs1 & busy_q[dec_rs1]) |
             (dec_has_rs2 & busy_q[dec_rs2]) |
             (dec_has_rd  & busy_q[dec_rd]);
    unit_ok = 1'b0;
    unique case (dec_exu_type)
      ExuAlu: unit_ok = !(dec_has_rd & slot_q[ALU_LAT]);
      ExuMul: unit_ok = !(dec_has_rd & slot_q[MUL_LAT]);
      ExuDiv: unit_ok = !div_busy_q;
      ExuMem: unit_ok = (mem_cnt_q < 3'(MEM_MAX)) | mem_done;
      default: unit_ok = 1'b0;
    endcase
    dec_ready = dec_valid & !rst & !flush & !hazard & unit_ok;
    fire      = dec_ready;
    issue_alu = fire & (dec_exu_type == ExuAlu);
    issue_mul = fire & (dec_exu_type == ExuMul);
    issue_div = fire & (dec_exu_type == ExuDiv);
    issue_mem = fire & (dec_exu_type == ExuMem);
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_valid && wb_rd != 5'd0) busy_d[wb_rd] = 1'b0;
    // Set after clear: a same-cycle clear always belongs to an older op.
    if (fire && dec_has_rd && dec_rd != 5'd0) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;

    div_busy_d = div_busy_q;
    if (issue_div)     div_busy_d = 1'b1;
    else if (div_done) div_busy_d = 1'b0;

    mem_cnt_d = mem_cnt_q;
    unique case ({issue_mem, mem_done})
      2'b10:   mem_cnt_d = mem_cnt_q + 3'd1;
      2'b01:   mem_cnt_d = mem_cnt_q - 3'd1;
      default: mem_cnt_d = mem_cnt_q;
    endcase

    slot_d = {1'b0, slot_q[MUL_LAT:2]};
    if (issue_alu && dec_has_rd) slot_d = slot_d | AluBit[MUL_LAT:1];
    if (issue_mul && dec_has_rd) slot_d = slot_d | MulBit[MUL_LAT:1];

    if (flush) begin
      busy_d     = '0;
      div_busy_d = 1'b0;
      mem_cnt_d  = '0;
      slot_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      div_busy_q <= 1'b0;
      mem_cnt_q  <= '0;
      slot_q     <= '0;
    end else begin
      busy_q     <= busy_d;
      div_busy_q <= div_busy_d;
      mem_cnt_q  <= mem_cnt_d;
      slot_q     <= slot_d;
    end
  end

  assign busy_vec = busy_q;
  assign mem_cnt  = mem_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: the driver queues hand-computed per-cycle
// expectations and a negedge monitor checks them against the DUT.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst, flush, dec_valid, dec_ready;
  logic [1:0]  dec_exu_type;
  logic        dec_has_rd, dec_has_rs1, dec_has_rs2;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        issue_alu, issue_mul, issue_div, issue_mem;
  logic        div_done, mem_done, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy_vec;
  logic [2:0]  mem_cnt;

  always #5 clk = ~clk;

  issue_scoreboard #(.MUL_LAT(3), .ALU_LAT(1), .MEM_MAX(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_exu_type(dec_exu_type),
    .dec_has_rd(dec_has_rd), .dec_has_rs1(dec_has_rs1), .dec_has_rs2(dec_has_rs2),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .issue_alu(issue_alu), .issue_mul(issue_mul), .issue_div(issue_div),
    .issue_mem(issue_mem), .div_done(div_done), .mem_done(mem_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy_vec(busy_vec), .mem_cnt(mem_cnt)
  );

  typedef struct {
    string       name;
    logic        ready;
    logic [3:0]  issue;  // {mem, div, mul, alu}
    logic [31:0] busy;
    logic [2:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (dec_ready !== e.ready) begin
        bad++;
        $display("FAIL %s ready: got %b want %b", e.name, dec_ready, e.ready);
      end
      total++;
      if ({issue_mem, issue_div, issue_mul, issue_alu} !== e.issue) begin
        bad++;
        $display("FAIL %s issue: got %b want %b", e.name,
                 {issue_mem, issue_div, issue_mul, issue_alu}, e.issue);
      end
      total++;
      if (busy_vec !== e.busy) begin
        bad++;
        $display("FAIL %s busy_vec: got %h want %h", e.name, busy_vec, e.busy);
      end
      total++;
      if (mem_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s mem_cnt: got %0d want %0d", e.name, mem_cnt, e.cnt);
      end
    end
  end

  task automatic set_op(input logic v, input logic [1:0] t, input logic hrd, input logic [4:0] rd,
                        input logic hr1, input logic [4:0] r1, input logic hr2,
                        input logic [4:0] r2);
    dec_valid = v; dec_exu_type = t;
    dec_has_rd = hrd; dec_rd = rd;
    dec_has_rs1 = hr1; dec_rs1 = r1;
    dec_has_rs2 = hr2; dec_rs2 = r2;
  endtask

  task automatic idle();
    set_op(1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic er, input logic [31:0] eb, input logic [2:0] ec);
    exp_t e;
    e.name  = nm;
    e.ready = er;
    e.issue = (er && dec_valid) ? (4'b0001 << dec_exu_type) : 4'b0000;
    e.busy  = eb;
    e.cnt   = ec;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; div_done = 1'b0; mem_done = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; div_done = 1'b0; mem_done = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;

    cyc("reset", 1'b0, 32'h0, 3'd0);

    // RAW stall on x5
    set_op(1, 0, 1, 5, 0, 0, 0, 0);   cyc("raw_issue", 1, 32'h0, 0);
    set_op(1, 0, 1, 8, 1, 5, 0, 0);   cyc("raw_stall", 0, 32'h20, 0);
    wb_valid = 1; wb_rd = 5;          cyc("raw_wb_cycle", 0, 32'h20, 0);
    cyc("raw_release", 1, 32'h0, 0);

    // x0 never busy
    set_op(1, 0, 1, 0, 0, 0, 0, 0);   cyc("x0_write", 1, 32'h100, 0);
    set_op(1, 0, 1, 0, 1, 0, 1, 0);
    wb_valid = 1; wb_rd = 8;          cyc("x0_read", 1, 32'h100, 0);
    idle();                           cyc("x0_idle", 0, 32'h0, 0);

    // Divider structural hazard
    set_op(1, 2, 1, 3, 0, 0, 0, 0);   cyc("div_issue", 1, 32'h0, 0);
    set_op(1, 2, 1, 4, 0, 0, 0, 0);   cyc("div_wait0", 0, 32'h8, 0);
    cyc("div_wait1", 0, 32'h8, 0);
    div_done = 1;                     cyc("div_done_cycle", 0, 32'h8, 0);
    cyc("div_after_done", 1, 32'h8, 0);
    idle(); wb_valid = 1; wb_rd = 3;  cyc("div_wb3", 0, 32'h18, 0);
    div_done = 1; wb_valid = 1; wb_rd = 4; cyc("div_wb4", 0, 32'h10, 0);
    cyc("div_clear", 0, 32'h0, 0);

    // Memory outstanding limit
    set_op(1, 3, 0, 0, 0, 0, 0, 0);   cyc("mem_a", 1, 32'h0, 0);
    cyc("mem_b", 1, 32'h0, 1);
    cyc("mem_full", 0, 32'h0, 2);
    mem_done = 1;                     cyc("mem_done_bypass", 1, 32'h0, 2);
    cyc("mem_full_again", 0, 32'h0, 2);
    idle(); mem_done = 1;             cyc("mem_drain1", 0, 32'h0, 2);
    mem_done = 1;                     cyc("mem_drain2", 0, 32'h0, 1);
    cyc("mem_empty", 0, 32'h0, 0);

    // Writeback slot collision (mul lat 3, alu lat 1)
    set_op(1, 1, 1, 6, 0, 0, 0, 0);   cyc("wb_mul_t", 1, 32'h0, 0);
    set_op(1, 0, 1, 7, 0, 0, 0, 0);   cyc("wb_alu_t1", 1, 32'h40, 0);
    set_op(1, 0, 1, 9, 0, 0, 0, 0);   cyc("wb_alu_t2", 0, 32'hC0, 0);
    cyc("wb_alu_t3", 1, 32'hC0, 0);
    idle(); wb_valid = 1; wb_rd = 6;  cyc("wb_clear6", 0, 32'h2C0, 0);

    // Flush mid-operation
    set_op(1, 0, 1, 5, 0, 0, 0, 0);   cyc("fl_alu5", 1, 32'h280, 0);
    set_op(1, 2, 1, 10, 0, 0, 0, 0);  cyc("fl_div", 1, 32'h2A0, 0);
    set_op(1, 3, 0, 0, 0, 0, 0, 0);   cyc("fl_mem", 1, 32'h6A0, 0);
    set_op(1, 0, 0, 0, 0, 0, 0, 0);
    flush = 1; wb_valid = 1; wb_rd = 9; mem_done = 1; cyc("fl_cycle", 0, 32'h6A0, 1);
    set_op(1, 2, 1, 11, 0, 0, 0, 0);  cyc("fl_div_ok", 1, 32'h0, 0);

    // Reset mid-operation
    set_op(1, 0, 1, 5, 0, 0, 0, 0);   cyc("rs_alu5", 1, 32'h800, 0);
    set_op(1, 3, 0, 0, 0, 0, 0, 0);   cyc("rs_mem", 1, 32'h820, 0);
    set_op(1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1; wb_valid = 1; wb_rd = 9; cyc("rs_cycle", 0, 32'h820, 1);
    set_op(1, 2, 1, 12, 0, 0, 0, 0);  cyc("rs_div_ok", 1, 32'h0, 0);
    idle();                           cyc("rs_final", 0, 32'h1000, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
